// File: rtl/product_bcd_display.sv
// ============================================================================
// product_bcd_display : serial double-dabble converter with registered
// BCD digits and active-low seven-segment patterns (leading-zero blanked).
// Revision: 1.0
// ============================================================================
`default_nettype none

module product_bcd_display #(
  parameter int N      = 4,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*N-1:0]        M,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int PW = 2 * N;
  localparam int BW = 4 * DIGITS;
  localparam int SW = 7 * DIGITS;
  localparam int CW = $clog2(PW + 1);
  localparam logic [SW-1:0] SEG_RESET = {{(SW-7){1'b1}}, 7'b1000000};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   bin_q,   bin_d;
  logic [BW-1:0]   work_q,  work_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [BW-1:0]   bcd_q,   bcd_d;
  logic [SW-1:0]   seg_q,   seg_d;
  logic            done_q,  done_d;

  logic [BW-1:0]   work_adj;
  logic [SW-1:0]   seg_next;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Add-3 correction on every digit, and segment patterns with leading zeros
  // blanked: walk from the top digit down, lighting once a non-zero is seen.
  always_comb begin
    logic       seen;
    logic [3:0] dig;
    work_adj = work_q;
    seg_next = '1;
    seen     = 1'b0;
    dig      = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = work_q[4*i +: 4];
      work_adj[4*i +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
    end
    for (int i = DIGITS - 1; i >= 0; i--) begin
      dig  = work_q[4*i +: 4];
      seen = seen | (dig != 4'd0);
      seg_next[7*i +: 7] = (seen || (i == 0)) ? seg7(dig) : 7'b1111111;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    seg_d   = seg_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = M;
          work_d  = '0;
          cnt_d   = CW'(PW);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {work_d, bin_d} = {work_adj, bin_q} << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        bcd_d   = work_q;
        seg_d   = seg_next;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      seg_q   <= SEG_RESET;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      seg_q   <= seg_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign bcd  = bcd_q;
  assign seg  = seg_q;

endmodule

`default_nettype wire

// File: tb/tb_product_bcd_display.sv
// ============================================================================
// tb_product_bcd_display : directed vectors with an arithmetic reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_product_bcd_display;

  localparam logic [6:0] BL = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  M = 8'd0;
  logic        start = 1'b0;
  logic        busy, done;
  logic [11:0] bcd;
  logic [20:0] seg;

  logic [15:0] M8 = 16'd0;
  logic        start8 = 1'b0;
  logic        busy8, done8;
  logic [19:0] bcd8;
  logic [34:0] seg8;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  product_bcd_display #(.N(4), .DIGITS(3)) u_dut (
    .clk(clk), .rst(rst), .M(M), .start(start),
    .busy(busy), .done(done), .bcd(bcd), .seg(seg)
  );

  product_bcd_display #(.N(8), .DIGITS(5)) u_dut8 (
    .clk(clk), .rst(rst), .M(M8), .start(start8),
    .busy(busy8), .done(done8), .bcd(bcd8), .seg(seg8)
  );

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int p;
    p = 1;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input int d);
    logic [6:0] t [10];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return t[d];
  endfunction

  function automatic logic [34:0] to_seg(input int v);
    logic [34:0] r;
    int top, p;
    top = 0;
    p = 1;
    for (int i = 0; i < 5; i++) begin
      if ((v / p) % 10 != 0) top = i;
      p = p * 10;
    end
    p = 1;
    for (int i = 0; i < 5; i++) begin
      r[7*i +: 7] = (i > top) ? BL : seg7((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model for the N=4 instance: a conversion occupies 2N+1 edges
  int          m_cnt  = 0;
  int          m_cap  = 0;
  logic        m_done = 1'b0;
  logic [11:0] m_bcd  = 12'h000;
  logic [20:0] m_seg  = {BL, BL, 7'b1000000};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_bcd  <= 12'h000;
      m_seg  <= 21'(to_seg(0));
    end else begin
      m_done <= 1'b0;
      if (m_cnt == 0) begin
        if (start) begin
          m_cap <= int'(M);
          m_cnt <= 9;
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_bcd  <= 12'(to_bcd(m_cap));
          m_seg  <= 21'(to_seg(m_cap));
          m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("busy", 64'(busy), 64'(m_cnt != 0));
    check("done", 64'(done), 64'(m_done));
    check("bcd",  64'(bcd),  64'(m_bcd));
    check("seg",  64'(seg),  64'(m_seg));
  end

  task automatic conv(input logic [7:0] m, input logic [11:0] eb, input logic [20:0] es);
    int k, nb;
    k = 0;
    nb = 0;
    @(negedge clk);
    M = m;
    start = 1'b1;
    do begin
      @(negedge clk);
      start = 1'b0;
      k++;
      if (busy) nb++;
    end while (!done && k < 40);
    check("latency4", 64'(k), 64'd10);
    check("busycycles4", 64'(nb), 64'd9);
    check("bcd_lit", 64'(bcd), 64'(eb));
    check("seg_lit", 64'(seg), 64'(es));
  endtask

  task automatic conv8(input logic [15:0] m, input logic [19:0] eb, input logic [34:0] es);
    int k;
    k = 0;
    @(negedge clk);
    M8 = m;
    start8 = 1'b1;
    do begin
      @(negedge clk);
      start8 = 1'b0;
      k++;
    end while (!done8 && k < 60);
    check("latency8", 64'(k), 64'd18);
    check("bcd8_lit", 64'(bcd8), 64'(eb));
    check("seg8_lit", 64'(seg8), 64'(es));
  endtask

  initial begin
    int k, nd, last;
    repeat (2) @(negedge clk);
    check("rst_bcd", 64'(bcd), 64'h000);
    check("rst_seg", 64'(seg), 64'({BL, BL, 7'b1000000}));
    check("rst_seg8", 64'(seg8), 64'({BL, BL, BL, BL, 7'b1000000}));
    rst = 1'b0;

    conv(8'd0,   12'h000, {BL, BL, 7'b1000000});
    conv(8'd225, 12'h225, {7'b0100100, 7'b0100100, 7'b0010010});
    conv(8'd100, 12'h100, {7'b1111001, 7'b1000000, 7'b1000000});
    conv(8'd7,   12'h007, {BL, BL, 7'b1111000});

    // start held high: results every 10 cycles, M change after capture is ignored
    @(negedge clk);
    M = 8'd42;
    start = 1'b1;
    repeat (3) @(negedge clk);
    M = 8'd99;
    k = 0; nd = 0; last = 0;
    while (nd < 3 && k < 60) begin
      @(negedge clk);
      k++;
      if (done) begin
        if (nd == 0) begin
          check("held_bcd", 64'(bcd), 64'h042);
          check("held_seg", 64'(seg), 64'({BL, 7'b0011001, 7'b0100100}));
        end else begin
          check("done_spacing", 64'(k - last), 64'd10);
          check("held_bcd2", 64'(bcd), 64'h099);
        end
        last = k;
        nd++;
      end
    end
    start = 1'b0;
    check("held_dones", 64'(nd), 64'd3);
    @(negedge clk);

    // asynchronous reset at E4 of a conversion
    M = 8'd255;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_bcd",  64'(bcd),  64'h000);
    check("arst_seg",  64'(seg),  64'({BL, BL, 7'b1000000}));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    k = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) k++;
    end
    check("no_done_after_abort", 64'(k), 64'd0);
    conv(8'd255, 12'h255, {7'b0100100, 7'b0010010, 7'b0010010});

    conv8(16'd65535, 20'h65535,
          {7'b0000010, 7'b0010010, 7'b0010010, 7'b0110000, 7'b0010010});
    conv8(16'd1000, 20'h01000,
          {BL, 7'b1111001, 7'b1000000, 7'b1000000, 7'b1000000});

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
